adc_ddr_tx_emulator: RTL and testbench
======================================

Name: adc_ddr_tx_emulator

Overview:
Fabric-side transmitter that emulates the AD9284 interleaved DDR output. It lets the LVDS receive path (IBUFDS/IODELAYE1/IDDR) be exercised in loopback with no ADC fitted. Each clock it produces one rising-edge byte (channel A) and one falling-edge byte (channel B), which drive 8 ODDR primitives plus a forwarded DCO. It first sends an alignment training sequence, then streams samples from a small FIFO or from built-in test patterns.

Parameters:
DATA_W, 8, sample width per channel
FIFO_DEPTH, 16, sample-pair FIFO depth; power of 2, at least 4
TRAIN_CYCLES, 64, number of training words sent after enable
TRAIN_A, 8'hA5, rising-edge training byte
TRAIN_B, 8'h5A, falling-edge training byte

Ports:
clock  in  1  single clock (DCO rate); all logic on the rising edge
reset_n  in  1  synchronous, active-low reset
enable  in  1  1 = transmit, 0 = return to IDLE
mode  in  2  RUN source: 0 FIFO, 1 ramp, 2 fixed, 3 checkerboard
fixed_value  in  2*DATA_W  mode 2 word: [15:8] rise, [7:0] fall
s_valid  in  1  sample pair valid
s_ready  out  1  FIFO can accept
s_data_a  in  DATA_W  channel A sample (rising edge)
s_data_b  in  DATA_W  channel B sample (falling edge)
data_rise  out  DATA_W  ODDR D1 inputs
data_fall  out  DATA_W  ODDR D2 inputs
dco_en  out  1  gates the forwarded DCO ODDR (D1=1, D2=0 when set)
training  out  1  high during TRAIN
underflow  out  1  sticky: FIFO empty while RUN and mode 0
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE; FIFO emptied; ramp counter and checker phase cleared.
  - All outputs 0, including s_ready, data_rise, data_fall, dco_en, training, underflow and fifo_level.
- s_ready = (state!=IDLE) && (fifo_level<FIFO_DEPTH). It is derived only from registered state; no combinational path from s_valid.
- Push occurs when s_valid && s_ready. In IDLE nothing is accepted.
- IDLE:
  - Outputs 0, dco_en=0, FIFO held empty. Entering IDLE flushes the FIFO and clears underflow.
  - enable=1 -> TRAIN on the next edge; train counter loaded with TRAIN_CYCLES-1.
- TRAIN:
  - data_rise=TRAIN_A, data_fall=TRAIN_B, training=1, dco_en=1.
  - Counter decrements each cycle; at 0 -> RUN. Exactly TRAIN_CYCLES training words are emitted.
  - FIFO may fill during TRAIN.
- RUN, dco_en=1, training=0:
  - Mode 0: if the FIFO is not empty, pop one pair; data_rise/data_fall show it on the next cycle, so pop-to-output latency is 1 clock. If empty, the outputs hold their last value and underflow is set (sticky).
  - Mode 1: data_rise=cnt, data_fall=cnt+1, then cnt+=2 modulo 2^DATA_W. Sequence: 00/01, 02/03 ... FE/FF, 00/01. cnt resets to 0 every time mode changes to 1.
  - Mode 2: data_rise=fixed_value[15:8], data_fall=fixed_value[7:0], sampled each cycle.
  - Mode 3: data_rise alternates 55,AA,55... starting with 55; data_fall is the bitwise inverse of data_rise.
  - In modes 1-3 the FIFO is neither popped nor flushed, and underflow does not change.
- enable=0 in TRAIN or RUN -> IDLE on the next edge; this edge's outputs are already 0.
- Mode changes take effect in the output one cycle after they are sampled.
- Push and pop in the same cycle leave fifo_level unchanged.
- Empty FIFO with a push in the same cycle: there is no bypass; that cycle counts as underflow, and the sample is output on the following pop.
- Full FIFO: s_ready=0, so no overwrite can occur.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_level ranges 0..FIFO_DEPTH.
- reset_n low mid-stream has the same effect as the reset above, applied on that edge.

Test Plan:
1. Reset, then enable=1, mode=0, no pushes -> exactly 64 cycles of A5/5A with training=1. Next cycle training=0 and underflow=1; outputs hold A5/5A.
2. Push 8 pairs (A=i, B=0x80+i) during TRAIN, mode=0 -> after training the outputs are 00/80, 01/81 ... 07/87 on consecutive cycles. fifo_level goes 8->0, and underflow=1 only after the 8th pair.
3. Mode=1 for 130 RUN cycles -> 00/01 ... FE/FF, then wraps to 00/01. Switch to mode 3 -> 55/AA, AA/55 alternating starting one cycle later.
4. Push continuously into a stalled FIFO (mode 2, fixed_value=16'h1234) -> s_ready drops after 16 accepts with fifo_level=16. Outputs stay 12/34; no data loss is seen when mode returns to 0.
5. Drop enable mid-RUN with 5 entries queued -> next cycle state IDLE, all outputs 0, fifo_level=0, underflow=0. Re-enable restarts the full 64-word training.
6. Assert reset_n=0 for one cycle mid-TRAIN with a push on the same edge -> push discarded, all outputs 0, state IDLE.

Source files
------------

// File: rtl/adc_ddr_tx_emulator.sv
// AD9284-style interleaved DDR transmitter for loopback testing of the LVDS receive path.
// Emits a training sequence, then FIFO samples or built-in test patterns as rise/fall byte pairs.
module adc_ddr_tx_emulator #(
  parameter int                DATA_W       = 8,
  parameter int                FIFO_DEPTH   = 16,
  parameter int                TRAIN_CYCLES = 64,
  parameter logic [DATA_W-1:0] TRAIN_A      = 8'hA5,
  parameter logic [DATA_W-1:0] TRAIN_B      = 8'h5A
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [1:0]                    mode,
  input  logic [2*DATA_W-1:0]           fixed_value,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_data_a,
  input  logic [DATA_W-1:0]             s_data_b,
  output logic [DATA_W-1:0]             data_rise,
  output logic [DATA_W-1:0]             data_fall,
  output logic                          dco_en,
  output logic                          training,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(TRAIN_CYCLES) + 1;
  localparam logic [LVL_W-1:0]  FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [DATA_W-1:0] CHK  = {(DATA_W/2){2'b01}};

  typedef enum logic [1:0] {S_IDLE, S_TRAIN, S_RUN} state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0]    train_cnt_q;

  logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [LVL_W-1:0]    level_q;
  logic                push, pop, flush, run_step;

  logic [DATA_W-1:0]   ramp_q, ramp_base;
  logic                chk_q, chk_base;
  logic [1:0]          mode_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (enable) state_d = S_TRAIN;
      S_TRAIN: begin
        if (!enable)                state_d = S_IDLE;
        else if (train_cnt_q == '0) state_d = S_RUN;
      end
      S_RUN:   if (!enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      train_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE)
        train_cnt_q <= CNT_W'(TRAIN_CYCLES - 1);
      else if (state_q == S_TRAIN && train_cnt_q != '0)
        train_cnt_q <= train_cnt_q - CNT_W'(1);
    end
  end

  // Outputs are registered against the next state, so they change on the same edge as the state.
  assign run_step   = (state_d == S_RUN);
  assign flush      = (state_d == S_IDLE);
  assign s_ready    = (state_q != S_IDLE) && (level_q < FULL);
  assign push       = s_valid && s_ready;
  assign pop        = run_step && (mode == 2'd0) && (level_q != '0);
  assign fifo_level = level_q;

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {s_data_a, s_data_b};
  end

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Pattern generators restart whenever their mode is newly selected.
  assign ramp_base = (mode_q == 2'd1) ? ramp_q : '0;
  assign chk_base  = (mode_q == 2'd3) ? chk_q  : 1'b0;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_rise <= '0;
      data_fall <= '0;
      dco_en    <= 1'b0;
      training  <= 1'b0;
      underflow <= 1'b0;
      ramp_q    <= '0;
      chk_q     <= 1'b0;
      mode_q    <= '0;
    end else begin
      mode_q <= mode;
      unique case (state_d)
        S_IDLE: begin
          data_rise <= '0;
          data_fall <= '0;
          dco_en    <= 1'b0;
          training  <= 1'b0;
          underflow <= 1'b0;
        end
        S_TRAIN: begin
          data_rise <= TRAIN_A;
          data_fall <= TRAIN_B;
          dco_en    <= 1'b1;
          training  <= 1'b1;
        end
        default: begin
          dco_en   <= 1'b1;
          training <= 1'b0;
          unique case (mode)
            2'd0: begin
              if (level_q != '0) {data_rise, data_fall} <= mem[rd_ptr];
              else               underflow <= 1'b1;
            end
            2'd1: begin
              data_rise <= ramp_base;
              data_fall <= ramp_base + DATA_W'(1);
              ramp_q    <= ramp_base + DATA_W'(2);
            end
            2'd2: begin
              data_rise <= fixed_value[2*DATA_W-1:DATA_W];
              data_fall <= fixed_value[DATA_W-1:0];
            end
            default: begin
              data_rise <= chk_base ? ~CHK : CHK;
              data_fall <= chk_base ? CHK : ~CHK;
              chk_q     <= ~chk_base;
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_ddr_tx_emulator.sv
// Scoreboard bench for adc_ddr_tx_emulator: a queue-based reference model predicts every
// post-edge output set; a negedge monitor pops and compares.
module tb_adc_ddr_tx_emulator;

  localparam int DEPTH = 16;
  localparam int TC    = 64;

  logic        clock = 1'b0;
  logic        reset_n, enable, s_valid, s_ready;
  logic [1:0]  mode;
  logic [15:0] fixed_value;
  logic [7:0]  s_data_a, s_data_b, data_rise, data_fall;
  logic        dco_en, training, underflow;
  logic [4:0]  fifo_level;

  always #5 clock = ~clock;

  adc_ddr_tx_emulator #(
    .DATA_W(8), .FIFO_DEPTH(DEPTH), .TRAIN_CYCLES(TC), .TRAIN_A(8'hA5), .TRAIN_B(8'h5A)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .mode(mode),
    .fixed_value(fixed_value), .s_valid(s_valid), .s_ready(s_ready),
    .s_data_a(s_data_a), .s_data_b(s_data_b), .data_rise(data_rise),
    .data_fall(data_fall), .dco_en(dco_en), .training(training),
    .underflow(underflow), .fifo_level(fifo_level)
  );

  typedef struct packed {
    logic [7:0] rise;
    logic [7:0] fall;
    logic       dco;
    logic       trn;
    logic       und;
    logic       rdy;
    logic [4:0] lvl;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc    = 0;

  // Reference model: activity flags, words left to train, sample queue, pattern counters.
  bit          m_train, m_run, m_und;
  int          m_left, m_ramp, m_chk_n;
  logic [15:0] m_fifo[$];
  logic [7:0]  m_rise, m_fall;
  logic [1:0]  m_prev;

  task automatic model_edge();
    bit          acc;
    logic [15:0] w;
    acc = s_valid && (m_train || m_run) && (m_fifo.size() < DEPTH);
    if (!reset_n) begin
      m_train = 0; m_run = 0; m_und = 0; m_left = 0; m_ramp = 0; m_chk_n = 0;
      m_fifo.delete(); m_rise = 0; m_fall = 0; m_prev = 0;
      return;
    end
    if (!enable) begin
      m_train = 0; m_run = 0; m_und = 0;
      m_fifo.delete(); m_rise = 0; m_fall = 0;
    end else if (!m_train && !m_run) begin
      m_train = 1; m_left = TC - 1; m_rise = 8'hA5; m_fall = 8'h5A;
    end else if (m_train && m_left > 0) begin
      m_left--; m_rise = 8'hA5; m_fall = 8'h5A;
    end else begin
      m_train = 0; m_run = 1;
      case (mode)
        2'd0: begin
          if (m_fifo.size() > 0) begin
            w = m_fifo.pop_front();
            m_rise = w[15:8]; m_fall = w[7:0];
          end else m_und = 1;
        end
        2'd1: begin
          if (m_prev != 2'd1) m_ramp = 0;
          m_rise = 8'(m_ramp); m_fall = 8'((m_ramp + 1) % 256);
          m_ramp = (m_ramp + 2) % 256;
        end
        2'd2: begin
          m_rise = fixed_value[15:8]; m_fall = fixed_value[7:0];
        end
        default: begin
          if (m_prev != 2'd3) m_chk_n = 0;
          m_rise = (m_chk_n % 2 == 0) ? 8'h55 : 8'hAA;
          m_fall = ~m_rise;
          m_chk_n++;
        end
      endcase
    end
    if (enable && acc) m_fifo.push_back({s_data_a, s_data_b});
    m_prev = mode;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.rise = m_rise;
    o.fall = m_fall;
    o.dco  = m_train || m_run;
    o.trn  = m_train;
    o.und  = m_und;
    o.rdy  = (m_train || m_run) && (m_fifo.size() < DEPTH);
    o.lvl  = 5'(m_fifo.size());
    return o;
  endfunction

  task automatic step();
    obs_t o;
    model_edge();
    o = model_obs();
    @(posedge clock);
    exp_q.push_back(o);
    #2;
  endtask

  task automatic run_cycles(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  always @(negedge clock) begin
    obs_t e, g;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = '{data_rise, data_fall, dco_en, training, underflow, s_ready, fifo_level};
      checks++;
      if (g === e) passes++;
      else
        $display("FAIL outputs cyc=%0d got rise=%h fall=%h dco=%b trn=%b und=%b rdy=%b lvl=%0d need rise=%h fall=%h dco=%b trn=%b und=%b rdy=%b lvl=%0d",
                 cyc, g.rise, g.fall, g.dco, g.trn, g.und, g.rdy, g.lvl,
                 e.rise, e.fall, e.dco, e.trn, e.und, e.rdy, e.lvl);
    end
  end

  initial begin
    reset_n = 0; enable = 0; mode = 0; fixed_value = '0;
    s_valid = 0; s_data_a = '0; s_data_b = '0;
    m_train = 0; m_run = 0; m_und = 0; m_left = 0; m_ramp = 0; m_chk_n = 0;
    m_rise = 0; m_fall = 0; m_prev = 0;

    run_cycles(3);
    reset_n = 1;
    step();

    // Training with empty FIFO, then underflow holding the training word
    enable = 1;
    run_cycles(70);

    // Eight pairs queued during training drain back-to-back afterwards
    enable = 0; step();
    enable = 1; step();
    for (int unsigned i = 0; i < 8; i++) begin
      s_valid = 1; s_data_a = 8'(i); s_data_b = 8'(8'h80 + i);
      step();
    end
    s_valid = 0;
    run_cycles(70);

    // Ramp through a full wrap, then checkerboard
    mode = 1; run_cycles(130);
    mode = 3; run_cycles(6);

    // Fill a stalled FIFO past full under fixed pattern, then drain it
    mode = 2; fixed_value = 16'h1234; s_valid = 1;
    for (int unsigned i = 0; i < 20; i++) begin
      s_data_a = 8'($urandom); s_data_b = 8'($urandom);
      step();
    end
    s_valid = 0; run_cycles(3);
    mode = 0; run_cycles(20);

    // Drop enable with entries queued, then full retrain
    mode = 2;
    for (int unsigned i = 0; i < 5; i++) begin
      s_valid = 1; s_data_a = 8'($urandom); s_data_b = 8'($urandom);
      step();
    end
    s_valid = 0; step();
    enable = 0; run_cycles(2);
    enable = 1; mode = 0; run_cycles(70);

    // Reset mid-training with a simultaneous push
    enable = 0; step();
    enable = 1; run_cycles(10);
    s_valid = 1; s_data_a = 8'h3C; s_data_b = 8'hC3; reset_n = 0; step();
    reset_n = 1; s_valid = 0; enable = 0; run_cycles(2);

    // Randomized traffic
    enable = 1;
    for (int unsigned i = 0; i < 1500; i++) begin
      reset_n     = ($urandom_range(0, 399) != 0);
      enable      = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
      fixed_value = 16'($urandom);
      s_valid     = ($urandom_range(0, 2) != 0);
      s_data_a    = 8'($urandom);
      s_data_b    = 8'($urandom);
      step();
    end
    s_valid = 0;
    run_cycles(2);

    @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain pending=%0d need 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
